// File: rtl/action_reset_sequencer.sv
// Sequences ResetDomains reset domains, in index order, behind the Donut request/done handshake.
// Define RESET_SEQ_TIMEOUT_EN to build the per-domain ready-timeout watchdog and FAULT reporting.
module action_reset_sequencer #(
    parameter int ResetDutyCycle     = 15,
    parameter int ResetCounterSize   = 4,
    parameter int ResetDomains       = 4,
    parameter int GapCycles          = 2,
    parameter int GapCounterSize     = 2,
    parameter int TimeoutCycles      = 1023,
    parameter int TimeoutCounterSize = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    donutRstReq,
    output logic                    donutRstDone,
    output logic                    donutRstError,
    output logic [ResetDomains-1:0] domainRst,
    input  logic [ResetDomains-1:0] domainRdy
);

    localparam int IdxW = (ResetDomains > 1) ? $clog2(ResetDomains) : 1;
    localparam logic [IdxW-1:0]             LastIdx  = IdxW'(ResetDomains - 1);
    localparam logic [ResetCounterSize-1:0] DutyLoad = ResetCounterSize'(ResetDutyCycle);
    localparam logic [GapCounterSize-1:0]   GapLoad  = GapCounterSize'(GapCycles);

    typedef enum logic [2:0] {
        S_HOLD,
        S_DUTY,
        S_WAIT_RDY,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                      r_state, w_state;
    logic [IdxW-1:0]             r_idx, w_idx;
    logic [ResetCounterSize-1:0] r_duty, w_duty;
    logic [GapCounterSize-1:0]   r_gap, w_gap;
    logic [ResetDomains-1:0]     r_domainRst, w_domainRst;
    logic                        r_done, w_done;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [TimeoutCounterSize-1:0] TmoLoad = TimeoutCounterSize'(TimeoutCycles);
    logic [TimeoutCounterSize-1:0] r_tmo, w_tmo;
    logic                          r_err, w_err;
`endif

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_duty      = r_duty;
        w_gap       = r_gap;
        w_domainRst = r_domainRst;
        w_done      = r_done;
`ifdef RESET_SEQ_TIMEOUT_EN
        w_tmo       = r_tmo;
        w_err       = r_err;
`endif
        if (donutRstReq) begin
            w_state     = S_DUTY;
            w_duty      = DutyLoad;
            w_idx       = '0;
            w_domainRst = '1;
            w_done      = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            w_err       = 1'b0;
`endif
        end else begin
            case (r_state)
                S_DUTY: begin
                    if (r_duty != '0) begin
                        w_duty = r_duty - ResetCounterSize'(1);
                    end else begin
                        w_domainRst[0] = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        w_tmo          = TmoLoad;
`endif
                        w_state        = S_WAIT_RDY;
                    end
                end
                // Ready is tested before the watchdog so a same-edge ready beats the timeout.
                S_WAIT_RDY: begin
                    if (domainRdy[r_idx]) begin
                        if (r_idx == LastIdx) begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_GAP;
                            w_gap   = GapLoad;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (r_tmo == '0) begin
                        w_state            = S_FAULT;
                        w_err              = 1'b1;
                        w_domainRst[r_idx] = 1'b1;
                    end else begin
                        w_tmo = r_tmo - TimeoutCounterSize'(1);
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap != '0) begin
                        w_gap = r_gap - GapCounterSize'(1);
                    end else begin
                        w_idx              = r_idx + IdxW'(1);
                        w_domainRst[w_idx] = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        w_tmo              = TmoLoad;
`endif
                        w_state            = S_WAIT_RDY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HOLD;
            r_idx       <= '0;
            r_duty      <= '0;
            r_gap       <= '0;
            r_domainRst <= '1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_duty      <= w_duty;
            r_gap       <= w_gap;
            r_domainRst <= w_domainRst;
            r_done      <= w_done;
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= w_tmo;
            r_err <= w_err;
        end
    end

    assign donutRstError = r_err;
`else
    assign donutRstError = 1'b0;
`endif

    assign donutRstDone = r_done;
    assign domainRst    = r_domainRst;

endmodule

// File: doc/action_reset_sequencer.md
# action_reset_sequencer

Next-generation action reset handler. It sequences a parametrised number of reset domains behind the Donut reset request/done handshake. Each domain is released in index order, with a configurable settling gap between domains and an optional per-domain ready-timeout watchdog that reports a fault to Donut. It sits between the Donut control interface and the action's reset domains, replacing the single-duty-cycle handler.

## Interface
- `ResetDutyCycle`, 15: clocks all domains stay in reset after a request, before domain 0 is released.
- `ResetCounterSize`, 4: duty counter width; must hold `ResetDutyCycle`.
- `ResetDomains`, 4: number of domains, ≥1.
- `GapCycles`, 2: extra settle clocks between domain *i* ready and domain *i+1* release; may be 0.
- `GapCounterSize`, 2: gap counter width, ≥1.
- `TimeoutCycles`, 1023: clocks allowed for `domainRdy[i]` after release of domain *i*.
- `TimeoutCounterSize`, 10: timeout counter width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `donutRstReq`  in  1  level restart request, sampled every edge.
- `donutRstDone`  out  1  all domains released and ready.
- `donutRstError`  out  1  ready timeout occurred.
- `domainRst`  out  ResetDomains  per-domain reset; index 0 is released first.
- `domainRdy`  in  ResetDomains  per-domain ready.

## Operation
- State machine states: HOLD, DUTY, WAIT_RDY, GAP, DONE, FAULT. A domain index `idx` is kept alongside the state.
- On `rst`: state goes to HOLD. `domainRst` is all ones, `donutRstDone`=0, `donutRstError`=0, all counters are 0.
- HOLD: keeps all domains in reset and waits for `donutRstReq`.
- `donutRstReq`=1 in any state takes priority over everything else:
  - state → DUTY, duty counter ← `ResetDutyCycle`, `idx` ← 0;
  - `domainRst` ← all ones, done ← 0, error ← 0.
- A request held high keeps reloading DUTY.
- DUTY:
  - If the counter is non-zero, decrement it.
  - If the counter is 0: `domainRst[0]` ← 0, timeout counter ← `TimeoutCycles`, state → WAIT_RDY.
- WAIT_RDY: `domainRdy[idx]` is checked first.
  - If `domainRdy[idx]`=1 and `idx`=`ResetDomains`-1: state → DONE, `donutRstDone` ← 1.
  - If `domainRdy[idx]`=1 otherwise: state → GAP, gap counter ← `GapCycles`.
  - Else, if the timeout counter is 0: state → FAULT, `donutRstError` ← 1, `domainRst[idx]` ← 1.
  - Else: decrement the timeout counter.
- GAP:
  - If the counter is non-zero, decrement it.
  - If the counter is 0: `idx` ← `idx`+1, `domainRst[idx+1]` ← 0, timeout counter reloaded, state → WAIT_RDY.
- DONE: outputs are held. Later `domainRdy` deassertion is ignored; readiness is sticky.
- FAULT:
  - Domains below `idx` stay released; `idx` and above stay in reset.
  - `donutRstDone` stays 0 and `donutRstError` stays 1.
  - The only exits are `donutRstReq` or `rst`.
- `domainRdy` bits for any index other than `idx` are ignored.
- Counters never wrap: each counter is only decremented when non-zero.
- All outputs are registered; there is no combinational input-to-output path.

## Timing
- Request sampled at edge E0 → `domainRst[0]` falls at edge E0+`ResetDutyCycle`+1.
- `domainRdy[i]` sampled high at edge Er → `domainRst[i+1]` falls at Er+`GapCycles`+1.
- Last domain's ready sampled at Er → `donutRstDone` rises at Er.
- Domain released at edge Erel with ready never asserted → FAULT, error rises at Erel+`TimeoutCycles`+1.
- Ready and timeout at the same edge: ready wins.
- `rst` asserted mid-sequence: outputs go to their reset values immediately, asynchronously. After `rst` deasserts, the block waits in HOLD for a request.
- `donutRstReq` mid-sequence or in DONE/FAULT: all domains are back in reset at the next edge and the sequence restarts.

## Configuration
- `RESET_SEQ_TIMEOUT_EN` defined:
  - the timeout counter and FAULT state are built as described above.
- `RESET_SEQ_TIMEOUT_EN` undefined:
  - no timeout counter is built and FAULT is unreachable;
  - WAIT_RDY waits indefinitely;
  - `donutRstError` is tied to 0, but the port remains.

## Test plan
- Defaults, pulse request, every `domainRdy` bit asserted 1 clock after its release:
  - `domainRst[0]` falls 16 clocks after the request edge;
  - each following domain falls 3 clocks after the previous domain's ready;
  - `donutRstDone`=1 when `domainRdy[3]` is sampled.
- `GapCycles`=0, `ResetDomains`=1, `domainRdy` tied 1:
  - `domainRst` falls at E0+16;
  - `donutRstDone` rises at E0+17.
- Timeout enabled, `TimeoutCycles`=7, `domainRdy[1]` held 0:
  - `donutRstError` rises 8 clocks after `domainRst[1]` falls;
  - `domainRst` reads 4'b1110 at the time of the fault and stays there;
  - done stays 0;
  - a subsequent request clears the error and restarts.
- `domainRdy[2]` asserted on exactly the edge where the timeout counter is 0 → no error and the sequence proceeds.
- `rst` pulsed while in GAP, then a request:
  - `domainRst`=4'b1111 immediately, done and error both 0;
  - the full sequence repeats with correct timing.
- Macro undefined, `domainRdy[0]` held 0 for 5000 clocks → `donutRstError` stays 0 and domain 1 stays in reset.
